cmdin_acc_sched: RTL and testbench

- Packet-level scheduler in front of the cmdin accelerator interconnection.
- Merges two command streams into one output stream at whole-packet granularity:
  - host-issued commands (source 0);
  - accelerator-created tasks from the spawn path (source 1).
- Tracks a per-accelerator busy bitmap. A packet is dispatched only when its target accelerator (tdest) is idle.
- The busy bit is released by a finish notification from the cmdout side.

---
 rtl/cmdin_acc_sched_if.sv | 14 +
 rtl/cmdin_acc_sched.sv | 117 +++++++++++
 tb/tb_cmdin_acc_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmdin_acc_sched_if.sv
// Packet stream channel (data/dest/last with valid/ready) used for the scheduler's
// two command inputs and its single output toward the interconnection.
interface cmdin_acc_sched_if #(
    parameter int DEST_W = 8
);
    logic [63:0]       data;
    logic [DEST_W-1:0] dest;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, output dest, output last, output valid, input  ready);
    modport slave  (input  data, input  dest, input  last, input  valid, output ready);
endinterface

// File: rtl/cmdin_acc_sched.sv
// Whole-packet scheduler merging host commands (s0) and spawned tasks (s1) onto one stream,
// dispatching a packet only when its target accelerator is idle in the busy bitmap.
module cmdin_acc_sched #(
    parameter int NUM_ACCS = 16,
    parameter int DEST_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cmdin_acc_sched_if.slave     s0,
    cmdin_acc_sched_if.slave     s1,
    cmdin_acc_sched_if.master    m,
    input  logic                 fin_valid,
    input  logic [DEST_W-1:0]    fin_id,
    output logic [NUM_ACCS-1:0]  busy,
    output logic                 err_dest
);

    typedef enum logic {IDLE, FWD} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_gsel;
    logic                r_rr;
    logic                r_err_dest;
    logic [NUM_ACCS-1:0] r_busy;

    logic [NUM_ACCS-1:0] w_oh0;
    logic [NUM_ACCS-1:0] w_oh1;
    logic [NUM_ACCS-1:0] w_fin_oh;
    logic [NUM_ACCS-1:0] w_grant_oh;
    logic                w_elig0;
    logic                w_elig1;
    logic                w_grant;
    logic                w_grant_sel;
    logic                w_pkt_done;

    // One-hot decodes; an out-of-range id simply decodes to all zeros.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACCS; gi++) begin : g_dec
            assign w_oh0[gi]      = (s0.dest == DEST_W'(gi));
            assign w_oh1[gi]      = (s1.dest == DEST_W'(gi));
            assign w_fin_oh[gi]   = fin_valid && (fin_id == DEST_W'(gi));
            assign w_grant_oh[gi] = w_grant && (w_grant_sel ? w_oh1[gi] : w_oh0[gi]);
        end
    endgenerate

    assign w_elig0 = s0.valid && (|w_oh0) && !(|(w_oh0 & r_busy));
    assign w_elig1 = s1.valid && (|w_oh1) && !(|(w_oh1 & r_busy));

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_sel  = 1'b0;
        w_pkt_done   = 1'b0;
        m.data       = '0;
        m.dest       = '0;
        m.last       = 1'b0;
        m.valid      = 1'b0;
        s0.ready     = 1'b0;
        s1.ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_grant      = 1'b1;
                    w_grant_sel  = (w_elig0 && w_elig1) ? r_rr : w_elig1;
                    w_state_next = FWD;
                end
            end
            FWD: begin
                if (r_gsel) begin
                    m.data   = s1.data;
                    m.dest   = s1.dest;
                    m.last   = s1.last;
                    m.valid  = s1.valid;
                    s1.ready = m.ready;
                end else begin
                    m.data   = s0.data;
                    m.dest   = s0.dest;
                    m.last   = s0.last;
                    m.valid  = s0.valid;
                    s0.ready = m.ready;
                end
                if (m.valid && m.ready && m.last) begin
                    w_pkt_done   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= '0;
            r_rr       <= 1'b0;
            r_gsel     <= 1'b0;
            r_err_dest <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // A grant set overrides a same-cycle (necessarily spurious) finish on that id.
            r_busy  <= (r_busy & ~w_fin_oh) | w_grant_oh;
            if (w_grant) begin
                r_gsel <= w_grant_sel;
            end
            if (w_pkt_done) begin
                r_rr <= ~r_gsel;
            end
            r_err_dest <= r_err_dest | (s0.valid && !(|w_oh0)) | (s1.valid && !(|w_oh1));
        end
    end

    assign busy     = r_busy;
    assign err_dest = r_err_dest;

endmodule

// File: tb/tb_cmdin_acc_sched.sv
// Randomized bench for cmdin_acc_sched: packet sources, random finishes and m_ready,
// compared each cycle against a transaction-level model of ownership and the busy bitmap.
module tb_cmdin_acc_sched;
    localparam int NUM_ACCS = 16;
    localparam int DEST_W   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                fin_valid;
    logic [DEST_W-1:0]   fin_id;
    logic [NUM_ACCS-1:0] busy;
    logic                err_dest;

    always #5 clk = ~clk;

    cmdin_acc_sched_if #(.DEST_W(DEST_W)) s0_if ();
    cmdin_acc_sched_if #(.DEST_W(DEST_W)) s1_if ();
    cmdin_acc_sched_if #(.DEST_W(DEST_W)) m_if ();

    cmdin_acc_sched #(.NUM_ACCS(NUM_ACCS), .DEST_W(DEST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s0        (s0_if.slave),
        .s1        (s1_if.slave),
        .m         (m_if.master),
        .fin_valid (fin_valid),
        .fin_id    (fin_id),
        .busy      (busy),
        .err_dest  (err_dest)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Stimulus currently applied
    bit                sv   [2];
    logic [DEST_W-1:0] sd   [2];
    logic [63:0]       sdat [2];
    bit                sl   [2];
    bit                mr;
    bit                fv;
    logic [DEST_W-1:0] fid;
    bit                rst_req;

    // Packet sources
    bit act  [2];
    bit held [2];
    int len  [2];
    int beat [2];
    int pkt  [2];
    int left [2];
    bit bad0;
    int valid_pct;

    // Reference model: which source owns the output (-1 = none), preferred source, busy, err
    int              own;
    bit              pref;
    logic [NUM_ACCS-1:0] mbusy;
    bit              merr;

    task automatic gen_inputs();
        for (int i = 0; i < 2; i++) begin
            if (!act[i] && left[i] > 0) begin
                act[i]  = 1'b1;
                beat[i] = 0;
                len[i]  = $urandom_range(1, 4);
                pkt[i]++;
                sd[i]   = (i == 0 && bad0) ? DEST_W'(20) : DEST_W'($urandom_range(0, 5));
            end
            if (act[i]) begin
                sv[i]   = held[i] || ($urandom_range(0, 99) < valid_pct);
                sdat[i] = {8'(i), 24'(pkt[i]), 32'(beat[i])};
                sl[i]   = (beat[i] == len[i] - 1);
            end else begin
                sv[i]   = 1'b0;
                sdat[i] = '0;
                sl[i]   = 1'b0;
            end
        end
        mr  = ($urandom_range(0, 99) < 70);
        fv  = ($urandom_range(0, 2) == 0);
        fid = ($urandom_range(0, 9) == 0) ? DEST_W'($urandom_range(16, 200))
                                          : DEST_W'($urandom_range(0, 7));
    endtask

    task automatic apply();
        rst         = rst_req;
        s0_if.data  = sdat[0];
        s0_if.dest  = sd[0];
        s0_if.last  = sl[0];
        s0_if.valid = sv[0];
        s1_if.data  = sdat[1];
        s1_if.dest  = sd[1];
        s1_if.last  = sl[1];
        s1_if.valid = sv[1];
        m_if.ready  = mr;
        fin_valid   = fv;
        fin_id      = fid;
    endtask

    task automatic check_model();
        bit ev;
        ev = (own >= 0) ? sv[own] : 1'b0;
        check_eq("m_valid",  64'(m_if.valid),  64'(ev));
        check_eq("s0_ready", 64'(s0_if.ready), 64'((own == 0) ? mr : 1'b0));
        check_eq("s1_ready", 64'(s1_if.ready), 64'((own == 1) ? mr : 1'b0));
        check_eq("busy",     64'(busy),        64'(mbusy));
        check_eq("err_dest", 64'(err_dest),    64'(merr));
        if (ev) begin
            check_eq("m_data", m_if.data,       sdat[own]);
            check_eq("m_dest", 64'(m_if.dest),  64'(sd[own]));
            check_eq("m_last", 64'(m_if.last),  64'(sl[own]));
        end
    endtask

    task automatic update_model();
        bit hs;
        bit e0;
        bit e1;
        int nxt;
        int gid;
        if (rst_req) begin
            own   = -1;
            pref  = 1'b0;
            mbusy = '0;
            merr  = 1'b0;
            for (int i = 0; i < 2; i++) begin
                act[i]  = 1'b0;
                held[i] = 1'b0;
            end
            return;
        end
        hs  = (own >= 0) && sv[own] && mr;
        nxt = own;
        gid = -1;
        for (int i = 0; i < 2; i++) begin
            if (own == i && hs) begin
                held[i] = 1'b0;
                if (sl[i]) begin
                    act[i] = 1'b0;
                    left[i]--;
                end else begin
                    beat[i]++;
                end
            end else begin
                held[i] = sv[i];
            end
        end
        if (own < 0) begin
            e0 = sv[0] && (sd[0] < NUM_ACCS) && !mbusy[sd[0]];
            e1 = sv[1] && (sd[1] < NUM_ACCS) && !mbusy[sd[1]];
            if (e0 && e1)  nxt = int'(pref);
            else if (e0)   nxt = 0;
            else if (e1)   nxt = 1;
            if (nxt >= 0)  gid = int'(sd[nxt]);
        end else if (hs && sl[own]) begin
            pref = (own == 0);
            nxt  = -1;
        end
        if (fv && fid < NUM_ACCS) mbusy[fid] = 1'b0;
        if (gid >= 0)             mbusy[gid] = 1'b1;
        if ((sv[0] && sd[0] >= NUM_ACCS) || (sv[1] && sd[1] >= NUM_ACCS)) merr = 1'b1;
        own = nxt;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        gen_inputs();
        apply();
        @(negedge clk);
        check_model();
        update_model();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_req   = 1'b1;
        own       = -1;
        pref      = 1'b0;
        mbusy     = '0;
        merr      = 1'b0;
        bad0      = 1'b0;
        valid_pct = 80;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; held[i] = 1'b0; len[i] = 1; beat[i] = 0; pkt[i] = 0; left[i] = 0;
            sv[i] = 1'b0; sd[i] = '0; sdat[i] = '0; sl[i] = 1'b0;
        end
        mr = 1'b0; fv = 1'b0; fid = '0;
        apply();
        repeat (3) cycle();
        rst_req = 1'b0;

        // Random mixed traffic with contention on a few accelerators
        left[0] = 40;
        left[1] = 40;
        cyc = 0;
        while ((left[0] > 0 || left[1] > 0 || own >= 0) && cyc < 20000) begin
            cycle();
            cyc++;
        end
        check_eq("random_phase_done", 64'(cyc < 20000), 64'd1);

        // Source 0 head targets a nonexistent accelerator; source 1 must keep flowing
        bad0    = 1'b1;
        left[0] = 1;
        left[1] = 10;
        cyc = 0;
        while ((left[1] > 0 || own >= 0) && cyc < 5000) begin
            cycle();
            cyc++;
        end
        check_eq("bad_dest_s1_done",   64'(cyc < 5000), 64'd1);
        check_eq("bad_dest_s0_left",   64'(left[0]),    64'd1);
        check_eq("bad_dest_err_flag",  64'(err_dest),   64'd1);
        bad0    = 1'b0;
        left[0] = 0;
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        repeat (3) cycle();

        // Reset in the middle of a multi-beat packet
        valid_pct = 100;
        left[0] = 6;
        left[1] = 6;
        cyc = 0;
        while (!(own >= 0 && act[own] && beat[own] >= 1) && cyc < 2000) begin
            cycle();
            cyc++;
        end
        check_eq("midpkt_found", 64'(cyc < 2000), 64'd1);
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        check_eq("midpkt_model_idle", 64'(own), 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        check_eq("midpkt_busy_clear", 64'(busy), 64'd0);
        cyc = 0;
        while ((left[0] > 0 || left[1] > 0 || own >= 0) && cyc < 5000) begin
            cycle();
            cyc++;
        end
        check_eq("drain_done", 64'(cyc < 5000), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
